// File: rtl/hovalaag_link_pkg.sv
// Shared definitions for the hovalaag host link.
// Holds the link FSM state type, frame geometry constants, core pin bit
// positions and a helper that packs the core io_in pin byte.
// Optional feature macro used by the top level: HOST_LINK_BUSY_EN.
package hovalaag_link_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SEND      = 2'd2,
    ST_BUSY_WAIT = 2'd3
  } link_state_e;

  localparam int unsigned BEATS_PER_FRAME = 8;
  localparam int unsigned INSTR_BEATS     = 6;
  localparam int unsigned DATA_W          = 6;
  localparam int unsigned VAL_W           = 12;
  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned FRAME_W         = BEATS_PER_FRAME * DATA_W;
  localparam int unsigned INSTR_PAD_W     = INSTR_BEATS * DATA_W - INSTR_W;

  // core_io_in / core_io_out bit positions
  localparam int unsigned IO_CLK_BIT       = 0;
  localparam int unsigned IO_RSTN_BIT      = 1;
  localparam int unsigned IO_DATA_LSB      = 2;
  localparam int unsigned IO_OUT_VALID_BIT = 6;
  localparam int unsigned IO_OUT_BUSY_BIT  = 7;

  function automatic logic [7:0] pack_pins(input logic [DATA_W-1:0] data,
                                           input logic rst_n,
                                           input logic core_clk);
    return {data, rst_n, core_clk};
  endfunction

endpackage

// File: rtl/hovalaag_resp_fifo.sv
// Response FIFO for captured core output values.
// Ports:
//   clk_i, rst_i    host clock, synchronous active-high reset (empties FIFO)
//   push_i, data_i  write request and value
//   pop_i           read request; ignored when empty
//   data_o          head entry, driven to zero while empty
//   count_o         number of stored entries (0..DEPTH)
// Simultaneous push and pop are both honoured, also when full.
module hovalaag_resp_fifo
  import hovalaag_link_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = VAL_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop, do_push;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_FULL) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/hovalaag_host_link.sv
// Host-side driver for the 8-in/8-out hovalaag core pin interface.
// Serialises {instr, in_val} frames onto core_io_in as 8 two-cycle beats
// (phase L: core_clk=0, data changes; phase H: core_clk=1), generates the
// core reset sequence and collects 12-bit results into a response FIFO.
// Ports:
//   clk, rst                 host clock, synchronous active-high reset
//   s_valid/s_ready          frame request handshake (s_instr, s_in_val)
//   m_valid/m_ready          response handshake (m_out_val)
//   core_io_in               {data[5:0], rst_n, core_clk} to the core
//   core_io_out              [5:0] data, [6] out-valid, [7] busy from the core
// Optional: define HOST_LINK_BUSY_EN to honour core busy while idle.
module hovalaag_host_link
  import hovalaag_link_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RST_BEATS  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [INSTR_W-1:0] s_instr,
  input  logic [VAL_W-1:0]   s_in_val,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [VAL_W-1:0]   m_out_val,
  output logic [7:0]         core_io_in,
  input  logic [7:0]         core_io_out
);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BEAT_W = ($clog2(RST_BEATS) > 3) ? $clog2(RST_BEATS) : 3;
  localparam logic [BEAT_W-1:0] BEAT_ONE      = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] LO_BEAT       = BEAT_W'(BEATS_PER_FRAME - 2);
  localparam logic [BEAT_W-1:0] LAST_BEAT     = BEAT_W'(BEATS_PER_FRAME - 1);
  localparam logic [BEAT_W-1:0] LAST_RST_BEAT = BEAT_W'(RST_BEATS - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

  link_state_e         state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                phase_q, phase_d;   // 0 = phase L, 1 = phase H
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [7:0]          io_q, io_d;
  logic                push;
  logic [VAL_W-1:0]    push_val;
  logic [CNT_W-1:0]    fifo_count;
  logic                busy;

`ifdef HOST_LINK_BUSY_EN
  assign busy = core_io_out[IO_OUT_BUSY_BIT];
`else
  logic unused_busy;
  assign unused_busy = core_io_out[IO_OUT_BUSY_BIT];
  assign busy        = 1'b0;
`endif

  assign s_ready  = (state_q == ST_IDLE) && (fifo_count != FIFO_FULL_CNT) && !busy;
  assign m_valid  = (fifo_count != '0);
  assign push_val = {core_io_out[DATA_W-1:0], lo_q};

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    phase_d = phase_q;
    frame_d = frame_q;
    lo_d    = lo_q;
    push    = 1'b0;
    case (state_q)
      ST_RESET: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (beat_q == LAST_RST_BEAT) begin
            state_d = ST_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_ONE;
          end
        end
      end
      ST_IDLE: begin
        phase_d = 1'b0;
        beat_d  = '0;
        if (s_valid && s_ready) begin
          // Chunk 5 picks up instr[31:30] with zero padding above it.
          frame_d = {s_in_val, {INSTR_PAD_W{1'b0}}, s_instr};
          state_d = ST_SEND;
        end else if (busy) begin
          state_d = ST_BUSY_WAIT;
        end
      end
      ST_SEND: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          frame_d = frame_q >> DATA_W;
          if (beat_q == LO_BEAT) lo_d = core_io_out[DATA_W-1:0];
          if (beat_q == LAST_BEAT) begin
            push    = core_io_out[IO_OUT_VALID_BIT];
            state_d = ST_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_ONE;
          end
        end
      end
      ST_BUSY_WAIT: begin
        phase_d = ~phase_q;
        if (phase_q && !busy) state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Pins are registered from the next-state view so they line up with the state.
  always_comb begin
    io_d = '0;
    case (state_d)
      ST_RESET:     io_d = pack_pins('0, 1'b0, phase_d);
      ST_IDLE:      io_d = pack_pins('0, 1'b1, 1'b0);
      ST_SEND:      io_d = pack_pins(frame_d[DATA_W-1:0], 1'b1, phase_d);
      ST_BUSY_WAIT: io_d = pack_pins('0, 1'b1, phase_d);
      default:      io_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      beat_q  <= '0;
      phase_q <= 1'b0;
      frame_q <= '0;
      lo_q    <= '0;
      io_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      lo_q    <= lo_d;
      io_q    <= io_d;
    end
  end

  assign core_io_in = io_q;

  hovalaag_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (VAL_W)
  ) u_resp_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (push_val),
    .pop_i   (m_ready),
    .data_o  (m_out_val),
    .count_o (fifo_count)
  );

endmodule
